// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared FSM encoding, reset constants and helpers for the fetch stage
package if_fetch_stage_pkg;
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_BUF   = 2'd2
  } state_t;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response bus
//   req   fetch request valid (master -> slave)
//   addr  word-aligned fetch address (master -> slave)
//   ready rdata valid for the current request (slave -> master)
//   rdata fetched instruction word (slave -> master)
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_fetch_stage_if_id_reg: IF/ID pipeline register with load / hold / bubble control
//   clk, reset_n        clock, async active-low reset
//   load                capture instr_i/pc_i/pc8_i/adel_i as a valid instruction
//   bubble              insert NOP_INSTR with valid=0 (takes priority over load)
//   id_*                registered IF/ID contents; hold when neither load nor bubble
module if_fetch_stage_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc8_i,
  input  logic        adel_i,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_adel
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc8   <= '0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (bubble) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc8   <= '0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (load) begin
      id_instr <= instr_i;
      id_pc    <= pc_i;
      id_pc8   <= pc8_i;
      id_valid <= 1'b1;
      id_adel  <= adel_i;
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage (PC register, imem fetch FSM, fetch buffer, IF/ID)
//   clk, reset_n   clock, async active-low reset
//   npc_i          selected next PC; loaded into pc whenever an instruction enters IF/ID
//   stall_i        hold PC and IF/ID
//   flush_i        bubble IF/ID, drop fetch buffer, refetch at pc (only with IF_FLUSH_EN)
//   pc_o, pc4_o    current fetch PC and PC+4 (mod 2^32)
//   imem           instruction-memory master port
//   id_*           IF/ID register outputs (instr, pc, pc+8 link value, valid, misaligned flag)
// Build option: define IF_FLUSH_EN to enable flush_i.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            npc_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            pc4_o,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc8,
  output logic                   id_valid,
  output logic                   id_adel
);
  state_t      state, state_n;
  logic [31:0] pc, buf_q;
  logic        req_q, flush, fetch_hit, take, hold_buf, bubble, adel;
`ifdef IF_FLUSH_EN
  assign flush = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush = 1'b0;
`endif
  // take: an instruction (fresh or buffered) enters IF/ID and pc advances to npc_i.
  // hold_buf: a word arrived while decode stalls; park it so it is not lost.
  always_comb begin
    adel      = pc[1:0] != 2'b00;
    fetch_hit = state == S_FETCH && imem.ready;
    take      = !flush && !stall_i && (fetch_hit || state == S_BUF);
    hold_buf  = !flush && stall_i && fetch_hit;
    bubble    = flush || (state == S_FETCH && !imem.ready && !stall_i);
    state_n   = state == S_RST ? S_FETCH :
                hold_buf ? S_BUF :
                (state == S_BUF && (flush || !stall_i)) ? S_FETCH : state;
  end
  // req is registered off the next state so it is glitch-free and low through reset and S_RST.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_RST;
      req_q <= 1'b0;
      pc    <= RESET_PC;
      buf_q <= '0;
    end else begin
      state <= state_n;
      req_q <= state_n == S_FETCH;
      if (take) pc <= npc_i;
      if (hold_buf) buf_q <= imem.rdata;
    end
  assign pc_o      = pc;
  assign pc4_o     = pc + 32'd4;
  assign imem.req  = req_q;
  assign imem.addr = word_addr(pc);
  if_fetch_stage_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (take),
    .bubble   (bubble),
    .instr_i  (adel ? NOP_INSTR : state == S_BUF ? buf_q : imem.rdata),
    .pc_i     (pc),
    .pc8_i    (pc + 32'd8),
    .adel_i   (adel),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .id_pc8   (id_pc8),
    .id_valid (id_valid),
    .id_adel  (id_adel)
  );
endmodule
